// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and entry type for the store buffer
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_PW    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - load address match against buffered stores, youngest hit wins
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [PW-1:0]         i_head,
  input  logic [PW:0]           i_count,
  input  logic [SB_AW-1:0]      i_addr,
  output logic                  o_hit,
  output logic [SB_DW-1:0]      o_data
);
  logic [PW-1:0] w_idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PW'(k);
      if (((PW+1)'(k) < i_count) && (i_entries[w_idx].addr == i_addr)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order word store buffer sharing the data memory port with loads
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                     clk_mem,
  input  logic                     reset_mem,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  output logic [AW-1:0]            mem_A,
  output logic [DW-1:0]            mem_WD,
  output logic                     mem_wr,
  input  logic [DW-1:0]            mem_RD,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_empty
);
  localparam int PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] r_entries;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [PW:0]           r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_drain;
  logic          w_enq;
  logic          w_hit;
  logic [DW-1:0] w_fwd_data;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // A full buffer drains even under load traffic, so loads cannot starve retirement.
  assign w_drain = !w_empty && (w_full || !ld_valid);
  assign w_enq   = st_valid && st_ready;

  assign st_ready = !w_full || w_drain;
  assign ld_stall = w_full && ld_valid;
  assign mem_wr   = w_drain;
  assign mem_A    = w_drain ? r_entries[r_head].addr : ld_addr;
  assign mem_WD   = r_entries[r_head].data;
  assign ld_data  = w_hit ? w_fwd_data : mem_RD;
  assign sb_count = r_count;
  assign sb_empty = w_empty;

  sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_addr    (ld_addr),
    .o_hit     (w_hit),
    .o_data    (w_fwd_data)
  );

  always_ff @(posedge clk_mem) begin
    if (reset_mem) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_mem) begin
    if (!reset_mem && w_enq) r_entries[r_tail] <= '{addr: st_addr, data: st_data};
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed bench with queue-based reference model for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk_mem = 1'b0;
  logic        reset_mem = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_wr;
  logic [31:0] mem_RD;
  logic [2:0]  sb_count;
  logic        sb_empty;

  always #5 clk_mem = ~clk_mem;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk_mem(clk_mem), .reset_mem(reset_mem),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_wr(mem_wr), .mem_RD(mem_RD),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Data memory: preloaded with A000_0000+i, address 4 holds 0xAA.
  logic [31:0] dut_mem [0:63];
  bit          mem_init = 1'b0;
  assign mem_RD = dut_mem[mem_A[5:0]];
  always @(posedge clk_mem) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) dut_mem[i] <= (i == 4) ? 32'hAA : 32'hA000_0000 + i;
      mem_init <= 1'b1;
    end else if (mem_wr) begin
      dut_mem[mem_A[5:0]] <= mem_WD;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;
  st_t         q[$];
  logic [31:0] exp_mem [0:63];
  bit          model_ok = 1'b0;
  int          n;
  bit          e_drain, e_stall, e_ready;
  logic [31:0] e_data;

  always @(negedge clk_mem) begin
    if (!model_ok) begin
      for (int i = 0; i < 64; i++) exp_mem[i] = (i == 4) ? 32'hAA : 32'hA000_0000 + i;
      q.delete();
    end else begin
      n       = q.size();
      e_drain = (n > 0) && (n == DEPTH || !ld_valid);
      e_stall = (n == DEPTH) && ld_valid;
      e_ready = (n < DEPTH) || e_drain;
      chk("m_count", 32'(sb_count), 32'(n));
      chk("m_empty", 32'(sb_empty), 32'(n == 0));
      chk("m_st_ready", 32'(st_ready), 32'(e_ready));
      chk("m_mem_wr", 32'(mem_wr), 32'(e_drain));
      chk("m_ld_stall", 32'(ld_stall), 32'(e_stall));
      chk("m_mem_A", mem_A, e_drain ? q[0].a : ld_addr);
      if (e_drain) chk("m_mem_WD", mem_WD, q[0].d);
      if (ld_valid && !e_stall) begin
        e_data = exp_mem[ld_addr[5:0]];
        for (int i = 0; i < n; i++) if (q[i].a == ld_addr) e_data = q[i].d;
        chk("m_ld_data", ld_data, e_data);
      end
      if (e_drain) begin
        exp_mem[q[0].a[5:0]] = q[0].d;
        void'(q.pop_front());
      end
      if (reset_mem) q.delete();
      else if (st_valid && e_ready) q.push_back('{a: st_addr, d: st_data});
    end
    if (reset_mem) model_ok = 1'b1;
  end

  task automatic drive(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    @(posedge clk_mem);
    #1;
    reset_mem = r;
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    ld_valid  = lv;
    ld_addr   = la;
  endtask

  task automatic settle;
    @(negedge clk_mem);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk_mem);
    // reset while three stores are pending
    drive(0, 1, 20, 32'h1, 1, 9);
    drive(0, 1, 21, 32'h2, 1, 9);
    drive(0, 1, 22, 32'h3, 1, 9);
    drive(0, 0, 0, 0, 1, 9);
    settle(); chk("rst_pre_count", 32'(sb_count), 3);
    drive(1, 1, 23, 32'h4, 1, 9);
    drive(0, 0, 0, 0, 1, 9);
    settle();
    chk("rst_count", 32'(sb_count), 0);
    chk("rst_empty", 32'(sb_empty), 1);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_ld_stall", 32'(ld_stall), 0);

    // single store retires on the next idle cycle
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("single_mem_wr", 32'(mem_wr), 1);
    chk("single_mem_A", mem_A, 5);
    chk("single_mem_WD", mem_WD, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0);
    settle(); chk("single_empty", 32'(sb_empty), 1);

    // forwarding picks the youngest match
    drive(0, 1, 7, 32'h11, 1, 9);
    drive(0, 1, 7, 32'h22, 1, 9);
    drive(0, 0, 0, 0, 1, 7);
    settle(); chk("fwd_young", ld_data, 32'h22);
    drive(0, 0, 0, 0, 1, 8);
    settle(); chk("fwd_miss", ld_data, 32'hA000_0008);
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    settle(); chk("fwd_drained", 32'(sb_empty), 1);

    // fill under loads, then store into a full buffer
    for (int i = 0; i < 4; i++) drive(0, 1, 10 + i, 32'h100 + i, 1, 9);
    drive(0, 1, 14, 32'h104, 1, 9);
    settle();
    chk("full_count", 32'(sb_count), 4);
    chk("full_st_ready", 32'(st_ready), 1);
    chk("full_ld_stall", 32'(ld_stall), 1);
    chk("full_mem_wr", 32'(mem_wr), 1);
    chk("full_mem_A", mem_A, 10);
    drive(0, 0, 0, 0, 1, 9);
    settle();
    chk("full_count_held", 32'(sb_count), 4);
    chk("full_mem_A2", mem_A, 11);
    repeat (4) drive(0, 0, 0, 0, 0, 0);
    settle(); chk("full_drained", 32'(sb_empty), 1);

    // program-order retirement
    for (int i = 1; i <= 3; i++) drive(0, 1, i, 32'h200 + i, 1, 9);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      settle();
      chk("order_mem_A", mem_A, i);
      chk("order_mem_WD", mem_WD, 32'h200 + i);
    end
    drive(0, 0, 0, 0, 0, 0);
    settle(); chk("order_empty", 32'(sb_empty), 1);

    // load does not see a same-cycle store
    drive(0, 1, 4, 32'h55, 1, 4);
    settle(); chk("same_cycle_ld", ld_data, 32'hAA);
    drive(0, 0, 0, 0, 1, 4);
    settle(); chk("next_cycle_ld", ld_data, 32'h55);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    settle(); chk("final_empty", 32'(sb_empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
